// File: rtl/laser_hit_detector.sv
// Photodiode hit qualifier: synchronizes the sensor, rejects short glitches,
// counts qualified laser hits, flags over-long illumination and locks out after each pulse.
module laser_hit_detector #(
  parameter int unsigned MIN_ON  = 50000,
  parameter int unsigned MAX_ON  = 150000000,
  parameter int unsigned LOCKOUT = 100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sensor,
  input  logic       clear,
  output logic       hit,
  output logic [7:0] hit_count,
  output logic       fault,
  output logic       armed
);

  localparam logic [31:0] MIN_LAST  = 32'(MIN_ON - 1);
  localparam logic [31:0] MAX_LAST  = 32'(MAX_ON - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCKOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUAL,
    ST_LIT,
    ST_FAULTED,
    ST_LOCKED
  } state_e;

  logic [1:0]  sync_q;
  logic        sensor_s;
  state_e      state_q;
  logic [31:0] cnt_q;
  logic        hit_q;
  logic [7:0]  hit_count_q;
  logic        fault_q;
  logic        hit_set;
  logic        fault_set;

  // NOTE: the synchronizer is reset too, so a stale light level cannot leak
  // into the FSM after reset; post-reset light is always qualified from scratch.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], sensor};
    end
  end

  assign sensor_s  = sync_q[1];
  assign hit_set   = (state_q == ST_QUAL) && sensor_s && (cnt_q == MIN_LAST);
  assign fault_set = (state_q == ST_LIT)  && sensor_s && (cnt_q == MAX_LAST);

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      hit_q <= hit_set;

      unique case (state_q)
        ST_IDLE: begin
          if (sensor_s) begin
            state_q <= ST_QUAL;
            cnt_q   <= 32'd1;
          end else begin
            cnt_q   <= '0;
          end
        end
        ST_QUAL: begin
          if (!sensor_s) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            if (hit_set) state_q <= ST_LIT;
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_LIT: begin
          if (!sensor_s) begin
            state_q <= ST_LOCKED;
            cnt_q   <= '0;
          end else if (fault_set) begin
            state_q <= ST_FAULTED;
          end else begin
            cnt_q   <= cnt_q + 32'd1;
          end
        end
        ST_FAULTED: begin
          if (!sensor_s) begin
            state_q <= ST_LOCKED;
            cnt_q   <= '0;
          end
        end
        ST_LOCKED: begin
          if (cnt_q == LOCK_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase

      // clear wins over a same-cycle hit or fault event; FSM is untouched by it
      if (clear) begin
        hit_count_q <= '0;
      end else if (hit_set && (hit_count_q != 8'hFF)) begin
        hit_count_q <= hit_count_q + 8'd1;
      end

      if (clear) begin
        fault_q <= 1'b0;
      end else if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign hit       = hit_q;
  assign hit_count = hit_count_q;
  assign fault     = fault_q;
  assign armed     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_laser_hit_detector.sv
// Bench for laser_hit_detector: directed and random light pulses checked each cycle
// against a timestamp-based pulse model (small MIN_ON/MAX_ON/LOCKOUT).
module tb_laser_hit_detector;

  localparam int MIN_ON  = 4;
  localparam int MAX_ON  = 20;
  localparam int LOCKOUT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sensor = 1'b0;
  logic       clear = 1'b0;
  logic       hit;
  logic [7:0] hit_count;
  logic       fault;
  logic       armed;

  int n_checks = 0;
  int n_bad    = 0;

  laser_hit_detector #(
    .MIN_ON (MIN_ON),
    .MAX_ON (MAX_ON),
    .LOCKOUT(LOCKOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sensor   (sensor),
    .clear    (clear),
    .hit      (hit),
    .hit_count(hit_count),
    .fault    (fault),
    .armed    (armed)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: edge index n, pulse described by its start edge and the
  // edge after which the detector is ready again.
  int edge_n      = 0;
  bit m_in_pulse  = 0;
  int m_pulse_edge = 0;
  int m_idle_from = 0;
  bit m_hit       = 0;
  int m_count     = 0;
  bit m_fault     = 0;
  bit hist[$];

  task automatic model_edge();
    bit s;
    bit hit_ev;
    bit fault_ev;
    int age;
    edge_n++;
    hit_ev   = 0;
    fault_ev = 0;
    if (reset) begin
      hist.delete();
      m_in_pulse  = 0;
      m_idle_from = edge_n;
      m_hit       = 0;
      m_count     = 0;
      m_fault     = 0;
    end else begin
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      if (m_in_pulse) begin
        age = edge_n - m_pulse_edge;
        if (!s) begin
          m_in_pulse  = 0;
          m_idle_from = (age < MIN_ON) ? edge_n : edge_n + LOCKOUT;
        end else begin
          hit_ev   = (age == MIN_ON - 1);
          fault_ev = (age == MAX_ON - 1);
        end
      end else if (edge_n > m_idle_from && s) begin
        m_in_pulse   = 1;
        m_pulse_edge = edge_n;
      end
      m_hit = hit_ev;
      if (clear) m_count = 0;
      else if (hit_ev && m_count < 255) m_count++;
      if (clear) m_fault = 0;
      else if (fault_ev) m_fault = 1;
      hist.push_back(sensor);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check("hit",       32'(hit),       32'(m_hit));
    check("hit_count", 32'(hit_count), 32'(m_count));
    check("fault",     32'(fault),     32'(m_fault));
    check("armed",     32'(armed),
          32'((!m_in_pulse && edge_n >= m_idle_from) ? 1 : 0));
  endtask

  // len cycles of light then gap cycles dark; clear/reset pulsed at the given index (-1 = never)
  task automatic pulse(input int len, input int gap, input int clr_at, input int rst_at);
    for (int i = 0; i < len + gap; i++) begin
      sensor = (i < len);
      clear  = (i == clr_at);
      reset  = (i == rst_at);
      tick();
    end
    sensor = 1'b0;
    clear  = 1'b0;
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_armed", 32'(armed), 32'd1);
    check("reset_count", 32'(hit_count), 32'd0);

    pulse(3, 10, -1, -1);
    check("glitch_count", 32'(hit_count), 32'd0);
    pulse(4, 15, -1, -1);
    check("min_on_count", 32'(hit_count), 32'd1);

    pulse(0, 2, 0, -1);
    pulse(25, 15, -1, -1);
    check("stuck_fault", 32'(fault), 32'd1);
    check("stuck_count", 32'(hit_count), 32'd1);
    pulse(0, 3, 0, -1);
    check("clear_fault", 32'(fault), 32'd0);
    check("clear_count", 32'(hit_count), 32'd0);

    pulse(6, 3, -1, -1);
    pulse(6, 20, -1, -1);
    check("lockout_count", 32'(hit_count), 32'd1);
    pulse(6, 12, -1, -1);
    pulse(6, 20, -1, -1);
    check("relit_count", 32'(hit_count), 32'd3);

    pulse(4, 15, 5, -1);
    check("clear_on_hit", 32'(hit_count), 32'd0);

    pulse(10, 5, -1, 7);
    check("rst_lit_count", 32'(hit_count), 32'd0);
    pulse(5, 15, -1, 10);
    pulse(12, 15, -1, 1);
    check("rst_held_count", 32'(hit_count), 32'd1);

    pulse(0, 20, 0, -1);
    for (int k = 0; k < 260; k++) pulse(5, 12, -1, -1);
    check("saturate", 32'(hit_count), 32'd255);

    for (int k = 0; k < 150; k++) begin
      int len;
      int gap;
      int clr_at;
      int rst_at;
      len    = int'($urandom_range(1, 26));
      gap    = int'($urandom_range(0, 16));
      clr_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len + gap - 1)) : -1;
      rst_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, len + gap - 1)) : -1;
      pulse(len, gap, clr_at, rst_at);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/laser_hit_detector.md
# laser_hit_detector

Receive-side counterpart of the laser driver: qualifies a photodiode sensor input and reports a hit when a laser pulse is seen. It synchronizes the sensor and rejects glitches shorter than a minimum on-time. It flags a fault on light held longer than any legal laser pulse, and enforces a lockout after each pulse. It sits between the target's sensor pin and the scoring logic.

## Interface
Parameters:
- `MIN_ON`, 50000: cycles of continuous light needed to register a hit (1 ms at 50 MHz).
- `MAX_ON`, 150000000: light lasting this many cycles or more is a stuck/ambient fault (3 s; exceeds the 2 s laser on-time).
- `LOCKOUT`, 100000000: cycles during which the sensor is ignored after light drops.
- Legal range: 2 ≤ MIN_ON < MAX_ON < 2^32; 1 ≤ LOCKOUT < 2^32.

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous, active-high.
- `sensor`  in  1  asynchronous photodiode level; 1 = light present.
- `clear`  in  1  synchronous; zeroes `hit_count` and `fault`.
- `hit`  out  1  one-cycle pulse per qualified hit.
- `hit_count`  out  8  hits since reset/clear; saturates at 255.
- `fault`  out  1  sticky; set on over-long illumination.
- `armed`  out  1  high while in IDLE (ready for a new pulse).

## Operation
- `sensor` passes through a 2-FF synchronizer to `sensor_s`. The FSM uses only `sensor_s`.
- A 32-bit counter `cnt` is shared by all states.
- FSM states: IDLE, QUAL, LIT, FAULTED, LOCKED.
- IDLE: `cnt`=0. If `sensor_s`=1 → QUAL with `cnt`=1.
- QUAL: if `sensor_s`=0 → IDLE (glitch rejected, no hit). Otherwise, if `cnt`=MIN_ON-1 → LIT with `cnt`=MIN_ON, `hit`=1 for one cycle, and `hit_count` incremented. Otherwise `cnt`++.
- LIT: if `sensor_s`=0 → LOCKED with `cnt`=0. Otherwise, if `cnt`=MAX_ON-1 → FAULTED with `fault`=1. Otherwise `cnt`++.
- FAULTED: no counting. When `sensor_s`=0 → LOCKED with `cnt`=0. `fault` stays set until `clear` or `reset`.
- LOCKED: `sensor_s` is ignored. When `cnt`=LOCKOUT-1 → IDLE; otherwise `cnt`++. The block therefore stays exactly LOCKOUT cycles in LOCKED.
- `hit_count` increments by 1 per hit and holds at 255 (no wrap).
- `clear` takes priority over a same-cycle increment: `hit_count` reads 0 after that edge, though the `hit` pulse is still issued.
- `clear` takes priority over a same-cycle entry into FAULTED: `fault` reads 0, and the FSM still enters FAULTED.
- `clear` never alters FSM state or `cnt`.
- `armed` = (state == IDLE), decoded combinationally from the state register.

## Timing
- Reset (synchronous, asserted at a rising edge) sets:
  - `hit`=0, `hit_count`=0, `fault`=0;
  - state IDLE, so `armed`=1;
  - `cnt`=0 and both synchronizer flops 0.
- Reset mid-pulse aborts any qualification, lockout or fault. After reset deasserts, light that is still present is qualified from scratch (full MIN_ON).
- Sensor-to-FSM latency is 2 cycles. Take `sensor` sampled high at edge 0:
  - `sensor_s` goes high after edge 1;
  - the FSM enters QUAL at edge 2;
  - if light persists, `hit` is high in the cycle after edge MIN_ON+1.
- A pulse of exactly MIN_ON sampled cycles produces a hit. A pulse of MIN_ON-1 cycles produces none.
- Light continuously present for MAX_ON `sensor_s` cycles sets `fault` after edge MAX_ON+1 relative to edge 0. No second hit is reported for the same pulse.
- After light drops, the next QUAL entry occurs no earlier than LOCKOUT+1 cycles after LOCKED entry.
- Light present when LOCKED ends starts a new qualification immediately and counts as a new pulse.
- `hit` is never high on two consecutive cycles.

## Test plan
Use test parameters MIN_ON=4, MAX_ON=20, LOCKOUT=8.
- Reset, then `sensor`=1 for 3 cycles → `hit` never asserts, `hit_count`=0, `armed` back to 1 within 3 cycles of the light dropping.
- `sensor`=1 for exactly 4 cycles → one `hit` pulse 5 cycles after the first high sample; `hit_count`=1; `armed`=0 for the LIT + 8-cycle LOCKED span.
- `sensor`=1 for 25 cycles → one `hit`, `fault`=1 from cycle 21, `hit_count`=1. Then `sensor`=0 → LOCKED for 8 cycles then IDLE, `fault` still 1. Pulse `clear` → `fault`=0, `hit_count`=0.
- Second 6-cycle pulse starting 3 cycles after the first drops (inside lockout) → no second hit. The same pulse started 12 cycles after the drop → `hit_count`=2.
- 260 legal pulses → `hit_count` saturates at 255 with no wrap. `clear` on the same cycle as a `hit` → `hit_count`=0 afterwards.
- Assert `reset` during LIT and during LOCKED → all outputs at reset values next cycle. Sensor held high through reset → a hit occurs 5 cycles after the first post-reset edge.
